// File: rtl/daq_pkg.sv
// Shared DAQ definitions: arbiter state encoding, word width, watchdog terminator
// word and the DAQ type codes used by every producer.
package daq_pkg;

  localparam int DAQ_W = 32;

  localparam logic [DAQ_W-1:0] WD_TERM_WORD = 32'hFFFF_FFFF;

  // Type codes carried in the first word of each producer's packet.
  localparam logic [7:0] DAQT_ENDSTOP = 8'd32;
  localparam logic [7:0] DAQT_SENSOR  = 8'd40;
  localparam logic [7:0] DAQT_DRO     = 8'd48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/daq_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req after index `last`,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   owner,
  output logic            found
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW:0]       start;

  // rot[k] is requester (last+1+k) mod NREQ; a shift of NREQ wraps to req itself.
  always_comb begin
    start = {1'b0, last} + {{IW{1'b0}}, 1'b1};
    dbl   = {req, req} >> start;
    rot   = dbl[NREQ-1:0];
  end

  always_comb begin : pick
    int sum;
    sum   = 0;
    owner = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        sum = int'(start) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        owner = IW'(sum);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/daq_arbiter.sv
// Round-robin arbiter sharing the DAQ FIFO between sampling blocks, one packet per grant.
// Optional owner watchdog enabled by defining DAQ_ARB_WATCHDOG_EN.
module daq_arbiter
  import daq_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_PKT   = 4,
  parameter int FREE_BITS = 10,
  parameter int WD_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       grant,
  input  logic [NREQ*DAQ_W-1:0] in_data,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ-1:0]       in_end,
  input  logic [FREE_BITS-1:0]  fifo_free,
  output logic [DAQ_W-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_end,
  output logic                  stray_err,
  output logic                  wd_err,
  output logic [15:0]           pkt_count,
  output logic [1:0]            dbg_state
);

  localparam int IW = $clog2(NREQ);

  // Handshake: out_valid is a one-cycle write strobe with no ready; the
  // fifo_free >= MAX_PKT check at grant time guarantees room for the packet.
  arb_state_t        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d, last_q, last_d, pick_owner;
  logic              pick_found, room;
  logic [DAQ_W-1:0]  out_data_q, out_data_d, own_data;
  logic              out_valid_q, out_valid_d, out_end_q, out_end_d;
  logic              stray_q, stray_d, own_valid, own_end, wd_fire;
  logic [15:0]       pkt_q, pkt_d;
  logic [NREQ-1:0]   owner_oh, stray_mask;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last_q),
    .owner (pick_owner),
    .found (pick_found)
  );

  assign room = (fifo_free >= FREE_BITS'(MAX_PKT));

  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_end   = 1'b0;
    owner_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        own_data    = in_data[i*DAQ_W +: DAQ_W];
        own_valid   = in_valid[i];
        own_end     = in_end[i];
        owner_oh[i] = 1'b1;
      end
    end
  end

  // Only the owner while BUSY may write; everything else is dropped as stray.
  assign stray_mask = in_valid & ~((state_q == BUSY) ? owner_oh : '0);
  assign grant      = (state_q == GRANT) ? owner_oh : '0;

`ifdef DAQ_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           wd_err_q;

  assign wd_fire = (state_q == BUSY) && !own_valid && (wd_q == WDW'(1));

  always_comb begin
    wd_d = wd_q;
    if (state_q == GRANT || (state_q == BUSY && own_valid)) wd_d = WDW'(WD_CYCLES);
    else if (state_q == BUSY && wd_q != '0)                 wd_d = wd_q - WDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q     <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      wd_err_q <= wd_err_q | wd_fire;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_end_d   = 1'b0;
    pkt_d       = pkt_q;
    stray_d     = stray_q | (|stray_mask);
    case (state_q)
      IDLE: begin
        if (pick_found && room) begin
          owner_d = pick_owner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        last_d  = owner_q;
        state_d = BUSY;
      end
      BUSY: begin
        out_data_d  = own_data;
        out_valid_d = own_valid;
        out_end_d   = own_valid && own_end;
        if (own_valid && own_end) begin
          pkt_d   = pkt_q + 16'd1;
          state_d = IDLE;
        end else if (wd_fire) begin
          out_data_d  = WD_TERM_WORD;
          out_valid_d = 1'b1;
          out_end_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IW'(NREQ - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_end_q   <= 1'b0;
      stray_q     <= 1'b0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_end_q   <= out_end_d;
      stray_q     <= stray_d;
      pkt_q       <= pkt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_end   = out_end_q;
  assign stray_err = stray_q;
  assign pkt_count = pkt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_daq_arbiter.sv
// Randomized scoreboard bench for daq_arbiter: the bench plays the requesters,
// predicts grant order and forwarded words from a round-robin model.
module tb_daq_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_PKT   = 4;
  localparam int FREE_BITS = 10;
`ifdef DAQ_ARB_WATCHDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 1024;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req, grant, in_valid, in_end;
  logic [NREQ*32-1:0]   in_data;
  logic [FREE_BITS-1:0] fifo_free;
  logic [31:0]          out_data;
  logic                 out_valid, out_end, stray_err, wd_err;
  logic [15:0]          pkt_count;
  logic [1:0]           dbg_state;

  int total = 0;
  int bad   = 0;
  logic [32:0]     exp_q[$];
  logic [NREQ-1:0] gnt_q[$];
  int pend[NREQ];
  int model_last;
  int pkt_exp;

  always #5 clk = ~clk;

  daq_arbiter #(
    .NREQ(NREQ), .MAX_PKT(MAX_PKT), .FREE_BITS(FREE_BITS), .WD_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .in_data(in_data), .in_valid(in_valid), .in_end(in_end),
    .fifo_free(fifo_free), .out_data(out_data), .out_valid(out_valid),
    .out_end(out_end), .stray_err(stray_err), .wd_err(wd_err),
    .pkt_count(pkt_count), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Monitor: every output word and every grant cycle is matched against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_word: got %0h end=%0b, no word expected", out_data, out_end);
        end else begin
          check("out_word", {31'd0, out_end, out_data}, {31'd0, exp_q.pop_front()});
        end
      end
      if (grant != '0) begin
        if (gnt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_order: got %0b, no grant expected", grant);
        end else begin
          check("grant_order", grant, gnt_q.pop_front());
        end
      end
    end
  end

  function automatic int model_pick();
    for (int k = 1; k <= NREQ; k++)
      if (pend[(model_last + k) % NREQ] > 0) return (model_last + k) % NREQ;
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] r;
    r = NREQ'(1) << i;
    return r;
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) req[i] = (pend[i] > 0);
  endtask

  task automatic wait_grant(output int idx, output int lat);
    idx = -1;
    lat = 0;
    for (int c = 1; c <= 50 && idx < 0; c++) begin
      @(negedge clk);
      if (grant != '0) begin
        lat = c;
        for (int i = 0; i < NREQ; i++) if (grant[i]) idx = i;
      end
    end
    if (idx < 0) begin
      total++; bad++;
      $display("FAIL grant_timeout: got no grant in 50 cycles, expected one");
      finish_run();
    end
  endtask

  // Streams one packet from requester idx; optional stray word from stray_idx.
  task automatic send_pkt(input int idx, input int n, input int stray_idx);
    logic [31:0] d;
    for (int w = 0; w < n; w++) begin
      if (w > 0) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk); #1;
          in_valid = '0;
          in_end   = '0;
          in_end[idx] = 1'($urandom_range(0, 1));
          in_data[idx*32 +: 32] = $urandom;
        end
      end
      @(posedge clk); #1;
      in_valid = '0;
      in_end   = '0;
      d = $urandom;
      in_data[idx*32 +: 32] = d;
      in_valid[idx] = 1'b1;
      in_end[idx]   = (w == n - 1);
      exp_q.push_back({(w == n - 1), d});
      if (stray_idx >= 0 && w == 1) begin
        in_data[stray_idx*32 +: 32] = $urandom;
        in_valid[stray_idx] = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = '0;
    in_end   = '0;
    pend[idx]--;
    drive_req();
    pkt_exp++;
  endtask

  task automatic serve(input int len, input int stray_idx);
    int e, idx, lat;
    e = model_pick();
    gnt_q.push_back(onehot(e));
    wait_grant(idx, lat);
    check("grant_latency", lat, 2);
    model_last = e;
    if (idx >= 0) send_pkt(idx, len, stray_idx);
  endtask

  task automatic run_queue(input int fixed_len);
    int len;
    while (any_pend()) begin
      drive_req();
      if ($urandom_range(0, 3) == 0) begin
        fifo_free = FREE_BITS'($urandom_range(0, MAX_PKT - 1));
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("no_grant_low_free", grant, 0);
        end
        @(posedge clk); #1;
      end
      fifo_free = FREE_BITS'($urandom_range(MAX_PKT, 100));
      len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, MAX_PKT));
      serve(len, -1);
    end
  endtask

  initial begin
    int e, idx, lat, cnt;
    logic [31:0] d;
    rst_n = 1'b0;
    req = '0; in_data = '0; in_valid = '0; in_end = '0; fifo_free = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    model_last = NREQ - 1;
    pkt_exp = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_end", out_end, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stray", stray_err, 0);
    check("rst_wd_err", wd_err, 0);
    check("rst_pkt_count", pkt_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester, 3-word packet.
    pend[2] = 1; drive_req(); fifo_free = 100;
    serve(3, -1);
    @(negedge clk);
    check("pkt_count_single", pkt_count, pkt_exp);

    // Backpressure at the MAX_PKT boundary.
    @(posedge clk); #1;
    pend[0] = 1; drive_req(); fifo_free = 3;
    repeat (4) begin
      @(negedge clk);
      check("no_grant_free3", grant, 0);
    end
    @(posedge clk); #1;
    fifo_free = 4;
    serve(2, -1);

    // Contention with req = 1011, 2-word packets, then random rounds.
    pend[0] = 2; pend[1] = 2; pend[3] = 2;
    run_queue(2);
    @(negedge clk);
    check("pkt_count_contention", pkt_count, pkt_exp);
    repeat (3) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) pend[i] = $urandom_range(0, 3);
      run_queue(0);
    end
    @(negedge clk);
    check("pkt_count_random", pkt_count, pkt_exp);

    // Stray word from requester 2 while requester 1 owns the stream.
    check("stray_clear", stray_err, 0);
    @(posedge clk); #1;
    pend[1] = 1; drive_req(); fifo_free = 50;
    serve(4, 2);
    @(negedge clk);
    check("stray_set", stray_err, 1);
    check("pkt_count_stray", pkt_count, pkt_exp);

`ifdef DAQ_ARB_WATCHDOG_EN
    // Owner sends one word then goes silent.
    @(posedge clk); #1;
    pend[0] = 1; drive_req(); fifo_free = 100;
    e = model_pick();
    gnt_q.push_back(onehot(e));
    wait_grant(idx, lat);
    check("wd_grant_latency", lat, 2);
    model_last = e;
    @(posedge clk); #1;
    d = $urandom;
    in_data[idx*32 +: 32] = d;
    in_valid[idx] = 1'b1;
    exp_q.push_back({1'b0, d});
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    pend[idx] = 0; drive_req();
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    check("wd_word_out", out_valid, 1);
    cnt = 0;
    while (cnt < 3 * WD) begin
      @(negedge clk);
      cnt++;
      if (out_valid) break;
    end
    check("wd_delay", cnt, WD);
    check("wd_err_set", wd_err, 1);
    check("wd_pkt_count", pkt_count, pkt_exp);
    @(posedge clk); #1;
    pend[1] = 1; drive_req();
    serve(2, -1);
    @(negedge clk);
    check("pkt_count_after_wd", pkt_count, pkt_exp);
`else
    check("wd_err_tied", wd_err, 0);
`endif

    // Reset in the middle of a packet from requester 3.
    @(posedge clk); #1;
    pend[3] = 1; drive_req(); fifo_free = 100;
    e = model_pick();
    gnt_q.push_back(onehot(e));
    wait_grant(idx, lat);
    check("rst_test_grant_latency", lat, 2);
    model_last = e;
    @(posedge clk); #1;
    d = $urandom | 32'd1;
    in_data[idx*32 +: 32] = d;
    in_valid[idx] = 1'b1;
    exp_q.push_back({1'b0, d});
    @(posedge clk); #1;
    in_data[idx*32 +: 32] = $urandom;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_end", out_end, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_grant", grant, 0);
    check("midrst_pkt_count", pkt_count, 0);
    check("midrst_stray", stray_err, 0);
    check("midrst_wd_err", wd_err, 0);
    in_valid = '0; in_end = '0; req = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    exp_q.delete();
    gnt_q.delete();
    model_last = NREQ - 1;
    pkt_exp = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pend[1] = 1; drive_req();
    serve(2, -1);
    @(negedge clk);
    check("pkt_count_after_rst", pkt_count, pkt_exp);

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("gnt_q_drained", gnt_q.size(), 0);
    finish_run();
  end

endmodule
